// File: rtl/noc_bridge_pkg.sv
// noc_bridge_pkg: shared types and widths for the AXIS-to-NoC injection bridge
package noc_bridge_pkg;
  localparam int TDATAW = 512;
  localparam int TDESTW = 4;
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} bridge_state_t;
  typedef struct packed {
    logic              last;
    logic [TDESTW-1:0] dest;
    logic [TDATAW-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock FIFO with occupancy count and show-ahead head
// ports: clk, rst (async high), push/din write side, pop/head read side, count = occupancy
module axis_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign do_pop = pop && count != '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= (do_push && !do_pop) ? count + 1'b1 : (!do_push && do_pop) ? count - 1'b1 : count;
    end
endmodule

// File: rtl/axis_noc_bridge.sv
// axis_noc_bridge: round-robin packet arbiter of NCH AXIS streams into one NoC injection port
// ports: axis_rx_* per-channel inputs, cfg_dest_en/cfg_dest TDEST override, err_clr,
//        axis_tx_* FIFO output, fifo_count/pkt_count/err_len status
module axis_noc_bridge import noc_bridge_pkg::*; #(
  parameter int NCH    = 4,
  parameter int DATAW  = TDATAW,
  parameter int DESTW  = TDESTW,
  parameter int FIFOD  = 16,
  parameter int MAXLEN = 64,
  parameter int PKTCW  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           axis_rx_tvalid,
  output logic [NCH-1:0]           axis_rx_tready,
  input  logic [NCH*DATAW-1:0]     axis_rx_tdata,
  input  logic [NCH-1:0]           axis_rx_tlast,
  input  logic [NCH*DESTW-1:0]     axis_rx_tdest,
  input  logic [NCH-1:0]           cfg_dest_en,
  input  logic [NCH*DESTW-1:0]     cfg_dest,
  input  logic                     err_clr,
  output logic                     axis_tx_tvalid,
  input  logic                     axis_tx_tready,
  output logic [DATAW-1:0]         axis_tx_tdata,
  output logic                     axis_tx_tlast,
  output logic [DESTW-1:0]         axis_tx_tdest,
  output logic [$clog2(FIFOD):0]   fifo_count,
  output logic [PKTCW-1:0]         pkt_count,
  output logic                     err_len
);
  localparam int GW = $clog2(NCH);
  localparam int CW = $clog2(FIFOD) + 1;
  localparam int BW = $clog2(MAXLEN);
  bridge_state_t state;
  logic [GW-1:0] grant, rr_ptr, pick, idx, next_ptr;
  logic [BW-1:0] beat_cnt;
  logic acc, push, sel_last, force_last, full, set_err;
  fifo_entry_t entry, head;
  // first valid channel at or above rr_ptr; scanning downward lets the nearest one win
  always_comb begin
    pick = rr_ptr;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr) + k) % NCH);
      if (axis_rx_tvalid[idx]) pick = idx;
    end
  end
  always_comb begin
    axis_rx_tready = '0;
    for (int i = 0; i < NCH; i++)
      axis_rx_tready[i] = (grant == GW'(i)) && (state == PASS ? !full : state == DRAIN);
  end
  assign full = fifo_count == CW'(FIFOD);
  assign next_ptr = (grant == GW'(NCH - 1)) ? '0 : grant + 1'b1;
  assign acc = axis_rx_tvalid[grant] && axis_rx_tready[grant];
  assign sel_last = axis_rx_tlast[grant];
  assign force_last = beat_cnt == BW'(MAXLEN - 1);
  assign push = state == PASS && acc;
  assign set_err = push && !sel_last && force_last;
  assign entry = {sel_last | force_last,
                  cfg_dest_en[grant] ? cfg_dest[grant*DESTW +: DESTW] : axis_rx_tdest[grant*DESTW +: DESTW],
                  axis_rx_tdata[grant*DATAW +: DATAW]};
  axis_sync_fifo #(.DEPTH(FIFOD), .WIDTH($bits(fifo_entry_t))) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(entry),
    .pop(axis_tx_tvalid && axis_tx_tready), .head(head), .count(fifo_count)
  );
  assign axis_tx_tvalid = fifo_count != '0;
  assign axis_tx_tdata = head.data;
  assign axis_tx_tdest = head.dest;
  assign axis_tx_tlast = head.last;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      pkt_count <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= set_err | (err_len & ~err_clr);
      case (state)
        IDLE:
          if (|axis_rx_tvalid) begin
            grant <= pick;
            beat_cnt <= '0;
            state <= PASS;
          end
        PASS:
          if (acc) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (sel_last || force_last) pkt_count <= pkt_count + 1'b1;
            if (sel_last) begin
              rr_ptr <= next_ptr;
              state <= IDLE;
            end else if (force_last) state <= DRAIN;
          end
        DRAIN:
          if (acc && sel_last) begin
            rr_ptr <= next_ptr;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axis_noc_bridge.sv
// tb_axis_noc_bridge: table vectors, corner sequences and randomized traffic against a packet-level model
module tb_axis_noc_bridge;
  localparam int NCH = 4, DATAW = 512, DESTW = 4, FIFOD = 4, MAXLEN = 8, PKTCW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] axis_rx_tvalid, axis_rx_tready, axis_rx_tlast, cfg_dest_en;
  logic [NCH*DATAW-1:0] axis_rx_tdata;
  logic [NCH*DESTW-1:0] axis_rx_tdest, cfg_dest;
  logic err_clr, axis_tx_tvalid, axis_tx_tready, axis_tx_tlast, err_len;
  logic [DATAW-1:0] axis_tx_tdata;
  logic [DESTW-1:0] axis_tx_tdest;
  logic [$clog2(FIFOD):0] fifo_count;
  logic [PKTCW-1:0] pkt_count;
  always #5 clk = ~clk;
  axis_noc_bridge #(.NCH(NCH), .DATAW(DATAW), .DESTW(DESTW), .FIFOD(FIFOD), .MAXLEN(MAXLEN), .PKTCW(PKTCW)) dut (
    .clk(clk), .rst(rst), .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tready(axis_rx_tready),
    .axis_rx_tdata(axis_rx_tdata), .axis_rx_tlast(axis_rx_tlast), .axis_rx_tdest(axis_rx_tdest),
    .cfg_dest_en(cfg_dest_en), .cfg_dest(cfg_dest), .err_clr(err_clr),
    .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready), .axis_tx_tdata(axis_tx_tdata),
    .axis_tx_tlast(axis_tx_tlast), .axis_tx_tdest(axis_tx_tdest), .fifo_count(fifo_count),
    .pkt_count(pkt_count), .err_len(err_len)
  );
  typedef struct packed {
    logic [DATAW-1:0] data;
    logic [DESTW-1:0] dest;
    logic             last;
  } beat_t;
  typedef struct {
    int ch;
    int len;
    bit en;
    logic [DESTW-1:0] cfg;
    logic [DESTW-1:0] dest;
    int exp_beats;
    logic [DESTW-1:0] exp_dest;
    bit exp_err;
  } vec_t;
  beat_t stim [NCH][64];
  int blen [NCH];
  int rd [NCH];
  int npk [NCH];
  int pk_len [NCH][8];
  beat_t exp_q [$];
  int txi, mp, exp_pkts, n_tx, first_tx, checks, errors;
  bit exp_err;
  logic [DESTW-1:0] last_dest;
  vec_t tbl [6];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic clear_stim();
    for (int c = 0; c < NCH; c++) begin
      blen[c] = 0;
      rd[c] = 0;
      npk[c] = 0;
    end
    exp_q.delete();
    txi = 0;
  endtask
  task automatic add_pkt(input int c, input int len, input logic [DESTW-1:0] d);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      for (int w = 0; w < DATAW / 32; w++) x.data[w*32 +: 32] = $urandom;
      x.dest = d;
      x.last = (b == len - 1);
      stim[c][blen[c]] = x;
      blen[c]++;
    end
    pk_len[c][npk[c]] = len;
    npk[c]++;
  endtask
  // packet-level model: all loaded channels contend from the start, served round-robin,
  // packets truncated to MAXLEN beats with the overflow tail dropped
  task automatic model();
    int pi [NCH];
    int st [NCH];
    for (int c = 0; c < NCH; c++) begin
      pi[c] = 0;
      st[c] = 0;
    end
    for (int guard = 0; guard < 64; guard++) begin
      int c, len, n;
      c = -1;
      for (int k = 0; k < NCH; k++)
        if (c < 0 && pi[(mp + k) % NCH] < npk[(mp + k) % NCH]) c = (mp + k) % NCH;
      if (c < 0) break;
      len = pk_len[c][pi[c]];
      n = len < MAXLEN ? len : MAXLEN;
      for (int b = 0; b < n; b++) begin
        beat_t x;
        x = stim[c][st[c] + b];
        if (cfg_dest_en[c]) x.dest = cfg_dest[c*DESTW +: DESTW];
        x.last = (b == n - 1);
        exp_q.push_back(x);
      end
      exp_pkts++;
      if (len > MAXLEN) exp_err = 1'b1;
      st[c] += len;
      pi[c]++;
      mp = (c + 1) % NCH;
    end
  endtask
  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      axis_rx_tvalid[c] = rd[c] < blen[c];
      if (rd[c] < blen[c]) begin
        axis_rx_tdata[c*DATAW +: DATAW] = stim[c][rd[c]].data;
        axis_rx_tdest[c*DESTW +: DESTW] = stim[c][rd[c]].dest;
        axis_rx_tlast[c] = stim[c][rd[c]].last;
      end
    end
  endtask
  // runs sources and sink until all traffic is through (stop_acc=0) or stop_acc rx beats accepted
  task automatic run(input int rdy, input int max_cyc, input int stop_acc);
    int acc;
    bit done;
    acc = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      drive();
      axis_tx_tready = $urandom_range(99) < rdy;
      @(negedge clk);
      for (int c = 0; c < NCH; c++)
        if (axis_rx_tvalid[c] && axis_rx_tready[c]) begin
          rd[c]++;
          acc++;
        end
      if (axis_tx_tvalid && axis_tx_tready) begin
        checks++;
        if (txi >= exp_q.size()) begin
          errors++;
          $display("FAIL tx_extra: got beat dest %0d last %0d, expected no beat", axis_tx_tdest, axis_tx_tlast);
        end else begin
          if ({axis_tx_tdata, axis_tx_tdest, axis_tx_tlast} !== exp_q[txi]) begin
            errors++;
            $display("FAIL tx_beat[%0d]: got data %h dest %0d last %0d expected data %h dest %0d last %0d",
                     txi, axis_tx_tdata[63:0], axis_tx_tdest, axis_tx_tlast,
                     exp_q[txi].data[63:0], exp_q[txi].dest, exp_q[txi].last);
          end
          txi++;
        end
        n_tx++;
        last_dest = axis_tx_tdest;
        if (first_tx < 0) first_tx = cyc;
      end
      @(posedge clk);
      #1;
      if (stop_acc > 0) done = acc >= stop_acc;
      else begin
        done = txi == exp_q.size();
        for (int c = 0; c < NCH; c++) if (rd[c] != blen[c]) done = 1'b0;
      end
    end
    drive();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d of %0d tx beats", txi, exp_q.size());
    end
  endtask
  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr", err_len, 0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    axis_rx_tvalid = '0;
    axis_rx_tdata = '0;
    axis_rx_tlast = '0;
    axis_rx_tdest = '0;
    cfg_dest_en = '0;
    cfg_dest = '0;
    err_clr = 1'b0;
    axis_tx_tready = 1'b0;
    mp = 0;
    exp_pkts = 0;
    exp_err = 1'b0;
    clear_stim();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_tvalid", axis_tx_tvalid, 0);
    chk("rst_rx_tready", axis_rx_tready, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_err_len", err_len, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tbl[0] = '{0, 3, 1'b0, 4'd0, 4'd2, 3, 4'd2, 1'b0};
    tbl[1] = '{1, 2, 1'b1, 4'd3, 4'd0, 2, 4'd3, 1'b0};
    tbl[2] = '{2, 8, 1'b0, 4'd0, 4'd5, 8, 4'd5, 1'b0};
    tbl[3] = '{3, 11, 1'b1, 4'd9, 4'd1, 8, 4'd9, 1'b1};
    tbl[4] = '{0, 1, 1'b0, 4'd0, 4'd15, 1, 4'd15, 1'b0};
    tbl[5] = '{2, 9, 1'b0, 4'd0, 4'd7, 8, 4'd7, 1'b1};
    for (int i = 0; i < 6; i++) begin
      clear_stim();
      cfg_dest_en = '0;
      cfg_dest[tbl[i].ch*DESTW +: DESTW] = tbl[i].cfg;
      cfg_dest_en[tbl[i].ch] = tbl[i].en;
      add_pkt(tbl[i].ch, tbl[i].len, tbl[i].dest);
      model();
      n_tx = 0;
      first_tx = -1;
      run(100, 200, 0);
      chk($sformatf("vec%0d_beats", i), n_tx, tbl[i].exp_beats);
      chk($sformatf("vec%0d_dest", i), last_dest, tbl[i].exp_dest);
      chk($sformatf("vec%0d_err", i), err_len, tbl[i].exp_err);
      chk($sformatf("vec%0d_pkts", i), pkt_count, exp_pkts);
      chk($sformatf("vec%0d_latency", i), first_tx, 2);
      pulse_clr();
      cfg_dest_en = '0;
    end
    clear_stim();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NCH; c++) add_pkt(c, 2, DESTW'(c));
    model();
    run(100, 400, 0);
    chk("fair_pkts", pkt_count, exp_pkts);
    clear_stim();
    add_pkt(1, 6, 4'd6);
    model();
    run(0, 40, 4);
    axis_tx_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_fifo_count", fifo_count, FIFOD);
    chk("bp_rx_tready", axis_rx_tready, 0);
    chk("bp_tx_tvalid", axis_tx_tvalid, 1);
    chk("bp_accepted", rd[1], 4);
    @(posedge clk);
    #1;
    run(100, 100, 0);
    chk("bp_pkts", pkt_count, exp_pkts);
    clear_stim();
    add_pkt(2, 5, 4'd1);
    model();
    run(100, 40, 2);
    rst = 1'b1;
    axis_rx_tvalid = '0;
    #1;
    chk("mrst_tx_tvalid", axis_tx_tvalid, 0);
    chk("mrst_fifo_count", fifo_count, 0);
    chk("mrst_pkt_count", pkt_count, 0);
    chk("mrst_rx_tready", axis_rx_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mp = 0;
    exp_pkts = 0;
    exp_err = 1'b0;
    clear_stim();
    add_pkt(3, 4, 4'd5);
    model();
    run(100, 100, 0);
    chk("mrst_after_pkts", pkt_count, 1);
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      cfg_dest_en = NCH'($urandom);
      cfg_dest = (NCH*DESTW)'($urandom);
      for (int c = 0; c < NCH; c++) begin
        int n;
        n = $urandom_range(1, 3);
        for (int p = 0; p < n; p++) add_pkt(c, $urandom_range(1, 12), DESTW'($urandom));
      end
      model();
      run(70, 3000, 0);
      chk($sformatf("rnd%0d_pkts", r), pkt_count, exp_pkts);
      chk($sformatf("rnd%0d_err", r), err_len, exp_err);
      chk($sformatf("rnd%0d_fifo", r), fifo_count, 0);
      pulse_clr();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
